// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
//   lsu_state_e  : FSM states of the access sequencer
//   F3_*         : RV32I load/store funct3 encodings
//   be_gen       : byte enables for (funct3, addr[1:0])
//   op_supported : funct3 legal for the given direction
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr_lo;
      F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Unsigned sizes only exist for loads; 011/110/111 exist for nothing.
  function automatic logic op_supported(input logic       is_store,
                                        input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data formatter: picks the addressed byte/half lane of a
// 32-bit bus word and sign- or zero-extends it as funct3 demands.
//   funct3  : access size/sign
//   addr_lo : byte offset of the access within the word
//   rdata   : raw bus word
//   result  : aligned, extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result = {24'h000000, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result = {16'h0000, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit for the in-order RV32I pipeline.
// Takes the EX/MEM outputs (address, store data, funct3, mem-op flags),
// runs one access on a req/ack data bus, formats load data for MEM/WB and
// stalls the pipeline while the access is outstanding.
//
// Bus handshake: bus_req rises the cycle after the op is accepted and stays
// high, with bus_we/bus_addr/bus_be/bus_wdata frozen, until the cycle in
// which bus_ack is sampled high; that same cycle bus_rdata is valid. bus_ack
// is ignored whenever bus_req is low.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   valid_m, is_store_m      MEM-stage op present / direction
//   funct3_m, addr_m, wdata_m  access size, byte address, store data
//   bus_req/we/addr/be/wdata request side of the data bus
//   bus_ack, bus_rdata       completion side of the data bus
//   rdata_m                  formatted load result (held until next load)
//   stall_m                  freeze IF..MEM this cycle
//   done_m                   one-cycle pulse when an access retires
//   misalign_m               misaligned op seen in IDLE, no bus cycle
//   bus_err                  one-cycle pulse when an access timed out
//   state_dbg                current FSM state
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        is_store_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata_m,
  output logic        stall_m,
  output logic        done_m,
  output logic        misalign_m,
  output logic        bus_err,
  output lsu_state_e  state_dbg
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state;
  logic [7:0]  to_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        supported;
  logic        start;
  logic [31:0] wdata_rep;
  logic [31:0] load_result;

  always_comb begin
    supported  = op_supported(is_store_m, funct3_m);
    misalign_m = (state == IDLE) & valid_m &
                 ((((funct3_m == F3_H) | (funct3_m == F3_HU)) & addr_m[0]) |
                  ((funct3_m == F3_W) & (addr_m[1:0] != 2'b00)));
    start      = (state == IDLE) & valid_m & ~misalign_m & supported;
    stall_m    = start | (state == BUSY);

    case (funct3_m)
      F3_B, F3_BU: wdata_rep = {4{wdata_m[7:0]}};
      F3_H, F3_HU: wdata_rep = {2{wdata_m[15:0]}};
      default:     wdata_rep = wdata_m;
    endcase
  end

  // Formatting uses the offset captured at issue: bus_addr is word-aligned.
  lsu_load_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (bus_rdata),
    .result  (load_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      to_cnt    <= 8'd0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rdata_m   <= 32'd0;
      done_m    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      done_m  <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= BUSY;
            to_cnt    <= 8'd0;
            bus_req   <= 1'b1;
            bus_we    <= is_store_m;
            bus_addr  <= {addr_m[31:2], 2'b00};
            bus_be    <= be_gen(funct3_m, addr_m[1:0]);
            bus_wdata <= wdata_rep;
            funct3_q  <= funct3_m;
            addr_lo_q <= addr_m[1:0];
          end else if (valid_m && !misalign_m) begin
            // Unsupported funct3: retire as a no-op without touching the bus.
            state  <= DONE;
            done_m <= 1'b1;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            // Ack in the last allowed cycle still completes normally.
            if (!bus_we) rdata_m <= load_result;
            state   <= DONE;
            done_m  <= 1'b1;
            bus_req <= 1'b0;
            to_cnt  <= 8'd0;
          end else if (to_cnt == TO_LAST) begin
            if (!bus_we) rdata_m <= 32'd0;
            bus_err <= 1'b1;
            state   <= DONE;
            done_m  <= 1'b1;
            bus_req <= 1'b0;
            to_cnt  <= 8'd0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        // valid_m still shows the retiring op here; it must not restart.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases followed by random
// ops, each checked against a byte-level reference model.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        valid_m;
  logic        is_store_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] rdata_m;
  logic        stall_m;
  logic        done_m;
  logic        misalign_m;
  logic        bus_err;
  lsu_state_e  state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = 32'd0;

  lsu_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_m    (valid_m),
    .is_store_m (is_store_m),
    .funct3_m   (funct3_m),
    .addr_m     (addr_m),
    .wdata_m    (wdata_m),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .rdata_m    (rdata_m),
    .stall_m    (stall_m),
    .done_m     (done_m),
    .misalign_m (misalign_m),
    .bus_err    (bus_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_supported(input bit st, input logic [2:0] f3);
    if (f3 == 3'b011 || f3 >= 3'b110) return 1'b0;
    if (st && f3[2]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_misalign(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n   = m_size(f3);
    int off = ((a % 4) / n) * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = m_size(f3);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word);
    int n   = m_size(f3);
    int off = ((a % 4) / n) * n;
    logic [31:0] v = word >> (8 * off);
    if (n == 1) v = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    else if (n == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // ---------------- drivers ----------------
  // All driver tasks start and end at posedge+1.
  // ack_at: BUSY cycle index (0-based) in which ack is given; out of range = never.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    bit mis = m_misalign(f3, a);
    bit sup = m_supported(st, f3);
    bit to  = sup && (ack_at < 0 || ack_at >= TIMEOUT);
    int exp_stalls = !sup ? 0 : (to ? TIMEOUT + 1 : ack_at + 2);
    int stalls = 0;
    int busy_n = 0;
    int cyc = 0;
    bit done_seen = 0;

    if (!mis && sup && !st) model_rdata = to ? 32'd0 : m_load(f3, a, rd);
    exp_q.push_back(model_rdata);

    valid_m = 1'b1; is_store_m = st; funct3_m = f3; addr_m = a; wdata_m = wd;

    if (mis) begin
      @(negedge clk);
      chk("misalign", 32'(misalign_m), 32'd1);
      chk("mis_stall", 32'(stall_m), 32'd0);
      @(posedge clk); #1;
      valid_m = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("mis_no_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
      end
      chk("mis_rdata", rdata_m, exp_q.pop_front());
      return;
    end

    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) chk("no_misalign", 32'(misalign_m), 32'd0);
      if (stall_m) stalls++;
      if (done_m) begin
        done_seen = 1;
        chk("done_state", 32'(state_dbg), 32'(DONE));
        chk("done_req", 32'(bus_req), 32'd0);
        chk("bus_err", 32'(bus_err), 32'(to));
        chk("rdata", rdata_m, exp_q.pop_front());
        chk("stalls", 32'(stalls), 32'(exp_stalls));
      end else if (bus_req) begin
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_be), 32'(m_be(f3, a)));
        chk("bus_we", 32'(bus_we), 32'(st));
        if (st) chk("bus_wdata", bus_wdata, m_wdata(f3, wd));
        bus_ack   = (busy_n == ack_at);
        bus_rdata = bus_ack ? rd : $urandom;
        busy_n++;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (done_seen) valid_m = 1'b0;
      cyc++;
    end
    if (!done_seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      valid_m = 1'b0;
    end
    @(negedge clk);
    chk("done_once", 32'(done_m), 32'd0);
    chk("back_idle", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1;
  endtask

  // Idle cycles with stray acks, which must be ignored.
  task automatic idle_gap(input int n);
    repeat (n) begin
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      @(negedge clk);
      chk("gap_req", 32'(bus_req), 32'd0);
      chk("gap_rdata", rdata_m, model_rdata);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_be"}, 32'(bus_be), 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_rdata"}, rdata_m, 32'd0);
    chk({tag, "_done"}, 32'(done_m), 32'd0);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic reset_mid_busy();
    valid_m = 1'b1; is_store_m = 1'b0; funct3_m = F3_W; addr_m = 32'h200; wdata_m = 32'd0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmb_req1", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmb_req2", 32'(bus_req), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; valid_m = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    model_rdata = 32'd0;
    @(negedge clk);
    check_reset_outputs("rmb");
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rmb_idle", 32'(state_dbg), 32'(IDLE));
    chk("rmb_done", 32'(done_m), 32'd0);
    chk("rmb_rdata", rdata_m, 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0; valid_m = 1'b0; is_store_m = 1'b0; funct3_m = 3'd0;
    addr_m = 32'd0; wdata_m = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    run_op(1'b0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_const", rdata_m, 32'hDEADBEEF);
    run_op(1'b0, F3_B, 32'h103, 32'h0, 0, 32'h80123456);
    chk("lb_const", rdata_m, 32'hFFFFFF80);
    run_op(1'b0, F3_BU, 32'h103, 32'h0, 1, 32'h80123456);
    chk("lbu_const", rdata_m, 32'h00000080);
    run_op(1'b1, F3_H, 32'h102, 32'h0000BEEF, 3, 32'h0);
    chk("sh_keep", rdata_m, 32'h00000080);
    run_op(1'b0, F3_W, 32'h101, 32'h0, 0, 32'h0);
    run_op(1'b0, F3_W, 32'h104, 32'h0, -1, 32'h0);
    chk("to_zero", rdata_m, 32'h0);
    run_op(1'b0, F3_HU, 32'h106, 32'h0, 3, 32'hABCD1234);
    chk("hu_last_ack", rdata_m, 32'h0000ABCD);
    run_op(1'b0, 3'b011, 32'h108, 32'h0, 0, 32'h0);
    run_op(1'b1, F3_BU, 32'h10C, 32'h55, 0, 32'h0);
    idle_gap(3);
    reset_mid_busy();

    for (int i = 0; i < 60; i++) begin
      bit          st  = 1'($urandom_range(0, 1));
      logic [2:0]  f3  = 3'($urandom_range(0, 7));
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      int          ack = $urandom_range(0, 5);
      run_op(st, f3, a, wd, ack, rd);
      idle_gap($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
